// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Operands and opcode are latched on acceptance and held on the ALU
// inputs for ALU_LAT cycles. The result is then registered and returned to the
// winning requester with a valid/ready handshake. One operation is in flight at a time.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   reqN_valid/ready/op/a/b        request channel N (N = 0, 1); ready is combinational
//   respN_valid/ready              response channel N
//   resp_data                      shared registered result
//   alu_a/alu_b/alu_op             latched operands/opcode driven to the shared ALU
//   alu_result                     combinational ALU result
//   busy                           high whenever not idle
module alu_share_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned OPW     = 3,
   parameter int          ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy
);

   // Latencies below one collapse to a single settle cycle.
   localparam int unsigned LAT_EFF = (ALU_LAT < 1) ? 32'd1 : 32'(ALU_LAT);
   localparam int unsigned CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic               ptr_q, ptr_d;
   logic               owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [OPW-1:0]     op_q, op_d;
   logic               win;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   // Next-state, arbitration and handshake outputs.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      res_d       = res_q;
      win         = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               // A lone requester wins outright; the pointer only breaks ties.
               win = (req0_valid && req1_valid) ? ptr_q : req1_valid;
               req0_ready = ~win;
               req1_ready = win;
               a_d     = win ? req1_a  : req0_a;
               b_d     = win ? req1_b  : req0_b;
               op_d    = win ? req1_op : req0_op;
               owner_d = win;
               cnt_d   = CNT_W'(LAT_EFF - 1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               res_d   = alu_result;
               state_d = RESP;
            end
         end
         RESP: begin
            resp0_valid = ~owner_q;
            resp1_valid = owner_q;
            // Fairness pointer moves only on a completed response.
            if (owner_q ? resp1_ready : resp0_ready) begin
               ptr_d   = ~owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign resp_data = res_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. Three instances: ALU_LAT=1 (main
// function), ALU_LAT=4 (slow ALU model), ALU_LAT=3 (reset during execution).
module tb_alu_share_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [3];
   logic        r0v [3], r0r [3], s0v [3], s0r [3];
   logic        r1v [3], r1r [3], s1v [3], s1r [3];
   logic [2:0]  r0op [3], r1op [3], aop [3];
   logic [31:0] r0a [3], r0b [3], r1a [3], r1b [3];
   logic [31:0] rd [3], aa [3], ab [3], ar [3];
   logic        bsy [3];

   int passed = 0;
   int total  = 0;

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         default: return a;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
      alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(LAT)) u_dut (
         .clk(clk), .rst_n(rst_n[g]),
         .req0_valid(r0v[g]), .req0_ready(r0r[g]), .req0_op(r0op[g]),
         .req0_a(r0a[g]), .req0_b(r0b[g]),
         .resp0_valid(s0v[g]), .resp0_ready(s0r[g]),
         .req1_valid(r1v[g]), .req1_ready(r1r[g]), .req1_op(r1op[g]),
         .req1_a(r1a[g]), .req1_b(r1b[g]),
         .resp1_valid(s1v[g]), .resp1_ready(s1r[g]),
         .resp_data(rd[g]), .alu_a(aa[g]), .alu_b(ab[g]), .alu_op(aop[g]),
         .alu_result(ar[g]), .busy(bsy[g]));
      if (g == 1) begin : g_slow
         // Slow ALU: result valid only once inputs have been stable for 3 edges.
         logic [2:0]  stab = 3'd0;
         logic [66:0] prev = '0;
         always @(posedge clk) begin
            if ({aa[g], ab[g], aop[g]} != prev) stab <= 3'd1;
            else if (stab != 3'd7) stab <= stab + 3'd1;
            prev <= {aa[g], ab[g], aop[g]};
         end
         assign ar[g] = (stab >= 3'd3) ? alu_f(aop[g], aa[g], ab[g]) : 32'hDEADBEEF;
      end else begin : g_fast
         assign ar[g] = alu_f(aop[g], aa[g], ab[g]);
      end
   end

   typedef struct {
      logic        req;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction on the ALU_LAT=1 instance, starting in IDLE.
   task automatic do_vec(input vec_t v);
      if (v.req) begin
         r1op[0] = v.op; r1a[0] = v.a; r1b[0] = v.b; r1v[0] = 1'b1;
      end else begin
         r0op[0] = v.op; r0a[0] = v.a; r0b[0] = v.b; r0v[0] = 1'b1;
      end
      #1;
      chk("win_ready", v.req ? r1r[0] : r0r[0], 1);
      chk("lose_ready", v.req ? r0r[0] : r1r[0], 0);
      tick();
      r0v[0] = 1'b0; r1v[0] = 1'b0;
      #1;
      chk("alu_a", aa[0], v.a);
      chk("alu_b", ab[0], v.b);
      chk("alu_op", 32'(aop[0]), 32'(v.op));
      chk("exec_busy", bsy[0], 1);
      tick();
      chk("resp_valid", v.req ? s1v[0] : s0v[0], 1);
      chk("other_valid", v.req ? s0v[0] : s1v[0], 0);
      chk("resp_data", rd[0], v.exp);
      tick();
      chk("idle_busy", bsy[0], 0);
      chk("valid_drop", v.req ? s1v[0] : s0v[0], 0);
      chk("data_hold", rd[0], v.exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b0, 3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
      vecs[1] = '{1'b1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
      vecs[2] = '{1'b0, 3'd1, 32'h12340000, 32'h00005678, 32'h12345678};
      vecs[3] = '{1'b1, 3'd3, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000};
      vecs[4] = '{1'b1, 3'd7, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5};

      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         r0v[i] = 0; r1v[i] = 0; s0r[i] = 1; s1r[i] = 1;
         r0op[i] = 0; r1op[i] = 0; r0a[i] = 0; r0b[i] = 0; r1a[i] = 0; r1b[i] = 0;
      end
      repeat (3) tick();

      // Reset state.
      chk("rst_busy", bsy[0], 0);
      chk("rst_alu_a", aa[0], 0);
      chk("rst_resp_data", rd[0], 0);
      chk("rst_resp0_valid", s0v[0], 0);
      chk("rst_resp1_valid", s1v[0], 0);
      chk("rst_req0_ready", r0r[0], 0);
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      tick();

      // Table-driven single transactions.
      for (int k = 0; k < 5; k++) do_vec(vecs[k]);

      // Lone requester 1, back-to-back.
      for (int k = 1; k <= 3; k++) begin
         r1op[0] = 3'd2; r1a[0] = 32'(k); r1b[0] = 32'hFFFFFFFF; r1v[0] = 1'b1;
         #1;
         chk("lone_ready", r1r[0], 1);
         tick();
         tick();
         chk("lone_valid", s1v[0], 1);
         chk("lone_data", rd[0], ~32'(k));
         tick();
      end
      r1v[0] = 1'b0;
      tick();

      // Both requesting continuously from reset: grants alternate 0,1,0,1.
      rst_n[0] = 1'b0;
      tick();
      rst_n[0] = 1'b1;
      r0op[0] = 3'd2; r0a[0] = 32'h000000F0; r0b[0] = 32'h0000000F;
      r1op[0] = 3'd0; r1a[0] = 32'h000000FF; r1b[0] = 32'h0000000F;
      r0v[0] = 1'b1; r1v[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_ready0", r0r[0], (k % 2 == 0) ? 1 : 0);
         chk("rr_ready1", r1r[0], (k % 2 == 1) ? 1 : 0);
         tick();
         tick();
         chk("rr_valid", (k % 2 == 1) ? s1v[0] : s0v[0], 1);
         chk("rr_data", rd[0], (k % 2 == 1) ? 32'h0000000F : 32'h000000FF);
         tick();
      end
      r0v[0] = 1'b0; r1v[0] = 1'b0;
      tick();

      // Backpressure on requester 1 while requester 0 waits.
      s1r[0] = 1'b0;
      r1op[0] = 3'd1; r1a[0] = 32'h00FF0000; r1b[0] = 32'h000000FF; r1v[0] = 1'b1;
      #1;
      chk("bp_accept1", r1r[0], 1);
      tick();
      r1v[0] = 1'b0;
      tick();
      r0op[0] = 3'd2; r0a[0] = 32'h3; r0b[0] = 32'h5; r0v[0] = 1'b1; s0r[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_valid1", s1v[0], 1);
         chk("bp_data", rd[0], 32'h00FFFF00 ^ 32'h00FFFF00 ^ 32'h00FF00FF);
         chk("bp_ready0", r0r[0], 0);
         chk("bp_valid0", s0v[0], 0);
         if (c == 4) s1r[0] = 1'b1;
         tick();
      end
      #1;
      chk("bp_accept0", r0r[0], 1);
      tick();
      r0v[0] = 1'b0;
      tick();
      chk("bp_resp0", s0v[0], 1);
      chk("bp_resp0_data", rd[0], 32'h6);
      tick();

      // ALU_LAT=4 with slow ALU model.
      r0op[1] = 3'd1; r0a[1] = 32'hCAFE0000; r0b[1] = 32'h0000BABE; r0v[1] = 1'b1;
      #1;
      chk("l4_ready", r0r[1], 1);
      tick();
      r0v[1] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("l4_alu_a", aa[1], 32'hCAFE0000);
         chk("l4_alu_b", ab[1], 32'h0000BABE);
         chk("l4_no_valid", s0v[1], 0);
         tick();
      end
      chk("l4_valid", s0v[1], 1);
      chk("l4_data", rd[1], 32'hCAFEBABE);
      tick();
      chk("l4_idle", bsy[1], 0);

      // ALU_LAT=3: reset in the second execute cycle drops the operation.
      r1op[2] = 3'd0; r1a[2] = 32'h12345678; r1b[2] = 32'hFFFF0000; r1v[2] = 1'b1;
      #1;
      chk("rx_ready", r1r[2], 1);
      tick();
      r1v[2] = 1'b0;
      chk("rx_busy", bsy[2], 1);
      tick();
      #2;
      rst_n[2] = 1'b0;
      #1;
      chk("rx_busy_rst", bsy[2], 0);
      chk("rx_alu_a_rst", aa[2], 0);
      chk("rx_resp0_rst", s0v[2], 0);
      chk("rx_resp1_rst", s1v[2], 0);
      tick();
      rst_n[2] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rx_no_resp", s1v[2], 0);
         chk("rx_idle", bsy[2], 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
